// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit queue: serializer state encoding
// and the default parameter values used by uart_txq and txq_fifo.
package uart_pkg;

    // Default parameter values
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_DEPTH        = 4;
    localparam int DEF_CLKS_PER_BIT = 4;
    localparam int DEF_STOP_BITS    = 1;
    localparam int DEF_EDGE_WR      = 1;

    // Serializer state encoding (2-bit, kept as plain constants so that
    // older tools and waveform viewers see stable numeric values)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_txq_fifo.sv
// Small synchronous FIFO for the transmit queue. A push into a full FIFO
// is accepted only when a pop happens on the same edge; the head entry is
// presented combinationally on dout_o.
module txq_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        din_i,
    output logic [DATA_W-1:0]        dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     accept_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_ok;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign dout_o   = mem_q[rptr_q];
    assign pop_ok   = pop_i & ~empty_o;
    assign accept_o = push_i & (~full_o | pop_ok);

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two)
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no path can infer a latch.
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (accept_o) wptr_d = wptr_q + PTR_W'(1);
        if (pop_ok)   rptr_d = rptr_q + PTR_W'(1);
        case ({accept_o, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array write port
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array is deliberately not reset; zeroed pointers and count make stale entries unreachable.
        if (accept_o) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_txq.sv
// UART transmitter with a small input queue. Characters written by the CPU
// are queued in txq_fifo and shifted out as start bit, DATA_W data bits
// (LSB first) and STOP_BITS stop bits, CLKS_PER_BIT clocks per bit.
// Queued frames go out back-to-back with no idle gap.
module uart_txq
    import uart_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = DEF_STOP_BITS,
    parameter int EDGE_WR      = DEF_EDGE_WR
) (
    input  logic                     dblclk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [DATA_W-1:0]        din,
    input  logic                     clr_ovf,
    output logic                     txd,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LAST_STOP  = BIT_W'(STOP_BITS - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              ovf_q, ovf_d;
    logic              wr_q;
    logic              wr_qual;
    logic              pop;
    logic              accept;
    logic [DATA_W-1:0] head;

    // wr_q resets high so a wr held through reset is not seen as a rising edge
    assign wr_qual = (EDGE_WR != 0) ? (wr & ~wr_q) : wr;

    txq_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i    (dblclk),
        .rst_ni   (reset),
        .push_i   (wr_qual),
        .pop_i    (pop),
        .din_i    (din),
        .dout_o   (head),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty),
        .accept_o (accept)
    );

    assign txd      = txd_q;
    assign busy     = (state_q != ST_IDLE);
    assign overflow = ovf_q;

    // Serializer next-state: bit timing, shifting and FIFO pops
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    cnt_d   = CNT_RELOAD;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_RELOAD;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_RELOAD;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_RELOAD;
                    if (bit_q == LAST_STOP) begin
                        bit_d = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the state being entered, so txd is a clean register output
    always_comb begin
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // Sticky overflow: a dropped write sets it, clr_ovf clears it, set wins
    always_comb begin
        ovf_d = ovf_q;
        if (wr_qual && !accept) ovf_d = 1'b1;
        else if (clr_ovf)       ovf_d = 1'b0;
    end

    // Serializer, write-edge and overflow registers
    always_ff @(posedge dblclk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            wr_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            wr_q    <= wr;
            ovf_q   <= ovf_d;
        end
    end

endmodule
